// File: rtl/margin_topk_ctrl.sv
// Keeps the N_REGISTERS smallest margins of a streamed batch with their sample
// indices, evicting the current largest on a strictly smaller arrival, then drains them.
module margin_topk_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDX_WIDTH  = 8,
    parameter int N_REGISTERS = 4,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH+INDX_WIDTH-1:0] in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH+INDX_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam int W = DATA_WIDTH + INDX_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LAST_FILL = (ADDR_WIDTH + 1)'(N_REGISTERS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_REGISTERS - 1);

    typedef enum logic [2:0] {IDLE, FILL, SCAN, ACCEPT, DRAIN} state_t;

    state_t                  state;
    logic [W-1:0]            bank [N_REGISTERS];
    logic [N_REGISTERS-1:0]  valid;
    logic [ADDR_WIDTH:0]     fill_cnt;
    logic [ADDR_WIDTH-1:0]   scan_cnt;
    logic [ADDR_WIDTH-1:0]   drain_addr;
    logic [ADDR_WIDTH-1:0]   run_addr;
    logic [ADDR_WIDTH-1:0]   max_addr;
    logic [DATA_WIDTH-1:0]   run_max;
    logic [DATA_WIDTH-1:0]   max_data;

    logic                    in_xfer;
    logic                    out_xfer;
    logic [DATA_WIDTH-1:0]   scan_margin;
    logic                    scan_take;
    logic [DATA_WIDTH-1:0]   next_max;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    replace;
    logic                    drain_end;

    assign in_ready  = (state == FILL) || (state == ACCEPT);
    assign out_valid = (state == DRAIN) && valid[drain_addr];
    assign out_data  = bank[drain_addr];
    assign out_addr  = drain_addr;
    assign out_last  = out_valid && drain_end;
    assign busy      = (state != IDLE);

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Address 0 seeds the running max; later entries win only when strictly larger,
    // so the lowest address holds on ties.
    assign scan_margin = bank[scan_cnt][DATA_WIDTH-1:0];
    assign scan_take   = (scan_cnt == '0) || (scan_margin > run_max);
    assign next_max    = scan_take ? scan_margin : run_max;
    assign next_addr   = scan_take ? scan_cnt : run_addr;

    assign replace   = in_data[DATA_WIDTH-1:0] < max_data;
    assign drain_end = ({1'b0, drain_addr} == (fill_cnt - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            // NOTE: the bank is reset explicitly so no stale entry survives an aborted batch.
            for (int i = 0; i < N_REGISTERS; i++) bank[i] <= '0;
            valid      <= '0;
            fill_cnt   <= '0;
            scan_cnt   <= '0;
            drain_addr <= '0;
            run_addr   <= '0;
            max_addr   <= '0;
            run_max    <= '0;
            max_data   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        fill_cnt <= '0;
                        valid    <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (in_xfer) begin
                        bank[fill_cnt[ADDR_WIDTH-1:0]]  <= in_data;
                        valid[fill_cnt[ADDR_WIDTH-1:0]] <= 1'b1;
                        fill_cnt <= fill_cnt + 1'b1;
                        if (in_last) begin
                            drain_addr <= '0;
                            state      <= DRAIN;
                        end else if (fill_cnt == LAST_FILL) begin
                            scan_cnt <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    run_max  <= next_max;
                    run_addr <= next_addr;
                    scan_cnt <= scan_cnt + 1'b1;
                    if (scan_cnt == LAST_ADDR) begin
                        max_data <= next_max;
                        max_addr <= next_addr;
                        state    <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (in_xfer) begin
                        if (replace) bank[max_addr] <= in_data;
                        if (in_last) begin
                            drain_addr <= '0;
                            state      <= DRAIN;
                        end else if (replace) begin
                            scan_cnt <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_xfer) begin
                        if (drain_end) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            drain_addr <= drain_addr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_margin_topk_ctrl.sv
// Scoreboard bench for margin_topk_ctrl: a reference model of the kept set pushes
// expected drain entries; a negedge monitor pops and compares on each drain handshake.
module tb_margin_topk_ctrl;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    typedef struct {
        logic [DW+IW-1:0] data;
        logic [AW-1:0]    addr;
        logic             last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW+IW-1:0]  in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW+IW-1:0]  out_data;
    logic [AW-1:0]     out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    int   n_vectors = 0;
    int   n_miscompares = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [IW-1:0] m_idx [N];
    logic [DW-1:0] m_mar [N];
    int            m_cnt = 0;

    margin_topk_ctrl #(
        .DATA_WIDTH(DW), .INDX_WIDTH(IW), .N_REGISTERS(N), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the kept set; pushes the drain order when the batch closes.
    task automatic model_update(input int idx, input int m, input bit last);
        int mx;
        if (m_cnt < N) begin
            m_idx[m_cnt] = IW'(idx);
            m_mar[m_cnt] = DW'(m);
            m_cnt++;
        end else begin
            mx = 0;
            for (int i = 1; i < N; i++) if (m_mar[i] > m_mar[mx]) mx = i;
            if (DW'(m) < m_mar[mx]) begin
                m_idx[mx] = IW'(idx);
                m_mar[mx] = DW'(m);
            end
        end
        if (last) begin
            for (int i = 0; i < m_cnt; i++) begin
                exp_q.push_back('{data: {m_idx[i], m_mar[i]}, addr: AW'(i), last: (i == m_cnt - 1)});
            end
        end
    endtask

    task automatic begin_batch();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_cnt = 0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input int idx, input int m, input bit last, output int waited);
        logic [IW-1:0] i8;
        logic [DW-1:0] m16;
        i8  = IW'(idx);
        m16 = DW'(m);
        in_valid = 1'b1;
        in_data  = {i8, m16};
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_update(idx, m, last);
        if (last) check("drain_start_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_done();
        int n0;
        int cyc;
        n0  = done_cnt;
        cyc = 0;
        while (done_cnt == n0 && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) check("done_timeout", 32'd0, 32'd1);
        tick();
        tick();
        check("done_pulses", 32'(done_cnt - n0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("drain_data", 32'(out_data), 32'(mon_e.data));
                    check("drain_addr", 32'(out_addr), 32'(mon_e.addr));
                    check("drain_last", 32'(out_last), 32'(mon_e.last));
                end
            end
        end
    end

    initial begin
        int w;
        logic [DW+IW-1:0] held_data;
        logic [AW-1:0]    held_addr;

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fill four, then a smaller last sample evicts the max at addr 3.
        begin_batch();
        send(0, 10, 0, w);
        send(1, 20, 0, w);
        send(2, 30, 0, w);
        send(3, 40, 0, w);
        send(4, 5, 1, w);
        check("fill_scan_bubble", 32'(w), 32'd4);
        wait_done();

        // Ties and larger values are rejected without a rescan bubble.
        begin_batch();
        send(0, 10, 0, w);
        send(1, 20, 0, w);
        send(2, 30, 0, w);
        send(3, 40, 0, w);
        send(4, 40, 0, w);
        check("tie_after_scan", 32'(w), 32'd4);
        send(5, 45, 0, w);
        check("reject_no_bubble_a", 32'(w), 32'd0);
        send(6, 39, 1, w);
        check("reject_no_bubble_b", 32'(w), 32'd0);
        wait_done();

        // Tied max: lowest address is evicted.
        begin_batch();
        send(0, 50, 0, w);
        send(1, 50, 0, w);
        send(2, 10, 0, w);
        send(3, 20, 0, w);
        send(4, 5, 1, w);
        wait_done();

        // Short batch drains only its two entries, no scan.
        begin_batch();
        send(0, 7, 0, w);
        send(1, 3, 1, w);
        check("short_no_scan", 32'(w), 32'd0);
        wait_done();

        // Replacement bubble plus a downstream stall on addr 1.
        begin_batch();
        send(0, 100, 0, w);
        send(1, 200, 0, w);
        send(2, 300, 0, w);
        send(3, 400, 0, w);
        send(4, 150, 0, w);
        send(5, 120, 0, w);
        check("replace_bubble", 32'(w), 32'd4);
        send(6, 110, 1, w);
        check("replace_bubble_2", 32'(w), 32'd4);
        tick();
        out_ready = 1'b0;
        held_data = out_data;
        held_addr = out_addr;
        check("stall_addr", 32'(out_addr), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held_data));
            check("stall_addr_hold", 32'(out_addr), 32'(held_addr));
        end
        out_ready = 1'b1;
        wait_done();

        // Longer random batch.
        begin_batch();
        for (int i = 0; i < 12; i++) send(i, int'($urandom_range(0, 1000)), (i == 11), w);
        wait_done();

        // Reset mid-scan aborts and discards the batch.
        begin_batch();
        send(0, 11, 0, w);
        send(1, 22, 0, w);
        send(2, 33, 0, w);
        send(3, 44, 0, w);
        check("scan_busy", 32'(busy), 32'd1);
        check("scan_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_out_addr", 32'(out_addr), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        m_cnt = 0;
        tick();
        rst = 1'b0;
        tick();
        begin_batch();
        send(0, 9, 1, w);
        check("single_last", 32'(out_last), 32'd1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/margin_topk_ctrl.md
Name: margin_topk_ctrl

Overview:
- Sequencer for the margin-sampling selection stage: keeps the N_REGISTERS smallest margins of a streamed batch in an internal register bank, together with each margin's sample index.
- Finds the current largest kept margin with a sequential scan.
- Replaces that entry when a strictly smaller margin arrives.
- Drains the kept set downstream at end of batch.
- Sits between the margin computation stream and the sample-selection output.

Parameters:
- DATA_WIDTH, 16: margin value width, unsigned.
- INDX_WIDTH, 8: sample index width.
- N_REGISTERS, 4: number of kept entries; must be ≥2.
- ADDR_WIDTH, 2: register address width; equals $clog2(N_REGISTERS).

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: begin new batch; honoured only in IDLE.
- in_valid  in  1: input margin valid.
- in_ready  out  1: block accepts input this cycle.
- in_data  in  DATA_WIDTH+INDX_WIDTH: {index, margin}; margin in the low DATA_WIDTH bits.
- in_last  in  1: final sample of batch, qualified by the in_valid&in_ready handshake.
- out_valid  out  1: drain entry valid.
- out_ready  in  1: downstream accepts the drain entry.
- out_data  out  DATA_WIDTH+INDX_WIDTH: kept {index, margin}.
- out_addr  out  ADDR_WIDTH: register address of the drained entry.
- out_last  out  1: final drained entry.
- busy  out  1: state ≠ IDLE.
- done  out  1: one-cycle pulse after the final drain handshake.

Behaviour:
- Reset: all outputs 0, all bank entries and valid bits 0, fill count 0, state IDLE. Reset is asynchronous and may occur in any state; it aborts the batch and discards kept data.
- Handshakes:
  - Input transfer occurs on in_valid&in_ready.
  - Output transfer occurs on out_valid&out_ready.
  - out_data, out_addr and out_last stay stable while out_valid=1 and out_ready=0.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 → FILL; the fill counter and entry valid bits are cleared in the same cycle.
- FILL:
  - in_ready=1.
  - Each transfer writes bank[fill_cnt] and sets its valid bit, then fill_cnt increments.
  - Transfer with in_last=1 → DRAIN, whether or not the bank is full.
  - Transfer filling the last entry with in_last=0 → SCAN.
- SCAN:
  - in_ready=0. Lasts exactly N_REGISTERS cycles; visits addresses 0..N-1, one per cycle.
  - Running max updates only when the entry margin is strictly greater than the running max, so on ties the lowest address wins.
  - Next state is ACCEPT; max_addr and max_data are registered at the transition.
- ACCEPT:
  - in_ready=1. Comparison is unsigned on the margin fields only: replace iff in margin < max_data.
  - Replace with in_last=0: bank[max_addr] ← in_data (full {index, margin}) → SCAN.
  - No replace with in_last=0: stay in ACCEPT. max_addr is still valid, so no rescan is needed; back-to-back acceptance is allowed.
  - in_last=1: the replacement (if any) is applied in the same cycle → DRAIN.
- DRAIN:
  - Presents valid entries in address order 0..fill_cnt-1.
  - out_last=1 on entry fill_cnt-1.
  - After the last handshake: out_valid=0, done=1 for one cycle → IDLE.
- start outside IDLE is ignored. in_valid outside FILL/ACCEPT is ignored, with in_ready=0.
- Latency:
  - After the Nth fill transfer at cycle t, in_ready=0 for cycles t+1..t+N and returns to 1 at t+N+1.
  - The same N-cycle bubble follows every replacement.
  - First out_valid appears the cycle after the in_last transfer.

Test Plan:
- N=4; start, then in_data (idx,margin) = (0,10),(1,20),(2,30),(3,40),(4,5, last) → in_ready low exactly 4 cycles after the 4th transfer; drain emits (0,10),(1,20),(2,30),(4,5) at addr 0..3; out_last on addr 3; done pulses once.
- Fill 10,20,30,40, then (4,40),(5,45),(6,39, last) → 40 and 45 rejected with no SCAN bubble; 39 replaces addr 3; drain ends with (6,39).
- Fill 50,50,10,20, then (4,5, last) → replaces addr 0 (lowest tied max); drain emits (4,5),(1,50),(2,10),(3,20).
- Batch of 2 samples (0,7),(1,3,last) → drain emits 2 entries only, out_last on addr 1, no SCAN state visited.
- During drain, hold out_ready=0 for 5 cycles on addr 1 → out_data, out_addr and out_valid stable; order and count unchanged after release.
- Assert rst mid-SCAN → all outputs 0 immediately, busy=0; a new batch of 1 sample (0,9,last) drains exactly (0,9) with no stale entries.
